// File: rtl/sram_init_sequencer.sv
// sram_init_sequencer: fills a single-port cache SRAM with INIT_VALUE after
// reset or on flush, then passes client requests through to the macro and
// returns read data with a valid strobe, holding it stable between reads.
module sram_init_sequencer #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 88,
    parameter int unsigned MASK_W = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_req,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              rd_pend, rd_pend_nxt;
    logic [DATA_W-1:0] hold, hold_nxt;
    logic              accept;

    // State, sweep counter, pending-read flag and held read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_INIT;
            cnt     <= '0;
            rd_pend <= 1'b0;
            hold    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rd_pend <= rd_pend_nxt;
            hold    <= hold_nxt;
        end
    end

    // Next state and macro/client outputs; the macro port is a pass-through in RUN.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_pend_nxt = 1'b0;
        accept      = 1'b0;
        sram_en     = 1'b0;
        sram_wmode  = 1'b0;
        sram_wmask  = '0;
        sram_wdata  = '0;
        sram_addr   = '0;
        req_ready   = 1'b0;
        init_done   = 1'b0;

        unique case (state)
            ST_INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = '1;
                sram_addr  = cnt;
                sram_wdata = INIT_VALUE;
                cnt_nxt    = cnt + ADDR_W'(1);
                // flush_req is deliberately not looked at: the sweep never restarts
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                req_ready = !flush_req;
                sram_addr = req_addr;
                accept    = req_valid && !flush_req;
                sram_en   = accept;
                if (accept) begin
                    sram_wmode = req_write;
                    sram_wmask = req_wmask;
                    sram_wdata = req_wdata;
                end
                rd_pend_nxt = accept && !req_write;
                if (flush_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase

        // Reset is synchronous, so quiet the outputs directly while it is held.
        if (reset) begin
            sram_en    = 1'b0;
            sram_wmode = 1'b0;
            sram_wmask = '0;
            sram_wdata = '0;
            req_ready  = 1'b0;
            init_done  = 1'b0;
        end
    end

    // Response path: live macro data on the read-follow cycle, held value otherwise.
    always_comb begin
        hold_nxt  = rd_pend ? sram_rdata : hold;
        rsp_valid = rd_pend && !reset;
        rsp_rdata = hold;
        if (reset) begin
            rsp_rdata = '0;
        end else if (rd_pend) begin
            rsp_rdata = sram_rdata;
        end
    end

endmodule
